prgrom_port_arbiter: RTL and testbench

//  Arbitrates the single port of the 64KB program ROM between instruction fetch, the UART program loader and a debug reader.

---
 rtl/prgrom_arb_pkg.sv | 22 ++
 rtl/prgrom_starve_ctr.sv | 39 +++
 rtl/prgrom_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_prgrom_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prgrom_arb_pkg.sv
// rtl/prgrom_arb_pkg.sv - shared types and defaults for the program-ROM port arbiter
package prgrom_arb_pkg;

    localparam int ADDR_W_DEF     = 14;
    localparam int DATA_W_DEF     = 32;
    localparam int DBG_STARVE_DEF = 4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        LOAD    = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_IF   = 2'd1,
        G_LD   = 2'd2,
        G_DBG  = 2'd3
    } gnt_src_e;

endpackage

// File: rtl/prgrom_starve_ctr.sv
// rtl/prgrom_starve_ctr.sv - saturating debug-denial counter with forced-slot flag
module prgrom_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic enable_i,
    input  logic deny_i,
    input  logic clear_i,
    output logic force_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enable_i) begin
            if (clear_i) begin
                cnt_d = '0;
            end else if (deny_i && (cnt_q != CW'(LIMIT))) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/prgrom_port_arbiter.sv
// rtl/prgrom_port_arbiter.sv - program-ROM port arbiter: fetch, UART loader sessions, optional debug reader
// Debug reader port and its starvation counter exist only when PRGROM_DBG_PORT_EN is defined.
module prgrom_port_arbiter
    import prgrom_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef PRGROM_DBG_PORT_EN
    ,
    parameter int DBG_STARVE = DBG_STARVE_DEF
`endif
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    output logic              if_stall_o,
    input  logic              ld_mode_i,
    input  logic              ld_wr_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic              ld_ack_o,
    output logic [ADDR_W:0]   ld_count_o,
    output logic              cpu_hold_o,
    output logic              cpu_restart_o,
`ifdef PRGROM_DBG_PORT_EN
    input  logic              dbg_rd_req_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_valid_o,
`endif
    output logic              rom_en_o,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [DATA_W-1:0] rom_wdata_o,
    input  logic [DATA_W-1:0] rom_rdata_i
);

    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    arb_state_e      state_q, state_d;
    gnt_src_e        gnt, gsrc_q;
    logic            ack_q;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            stall;

`ifdef PRGROM_DBG_PORT_EN
    logic dbg_force;

    prgrom_starve_ctr #(
        .LIMIT (DBG_STARVE)
    ) u_starve (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .enable_i (reset_i && (state_q == RUN)),
        .deny_i   (if_req_i && dbg_rd_req_i && (gnt != G_DBG)),
        .clear_i  (gnt == G_DBG),
        .force_o  (dbg_force)
    );
`endif

    always_comb begin
        state_d = state_q;
        gnt     = G_NONE;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (ld_mode_i) begin
                    state_d = DRAIN;
                end
`ifdef PRGROM_DBG_PORT_EN
                if (dbg_rd_req_i && (!if_req_i || dbg_force)) begin
                    gnt   = G_DBG;
                    stall = if_req_i;
                end else if (if_req_i) begin
                    gnt = G_IF;
                end
`else
                if (if_req_i) begin
                    gnt = G_IF;
                end
`endif
            end
            DRAIN: begin
                stall   = 1'b1;
                cnt_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                stall = 1'b1;
                // The ack cycle never regrants, capping the loader at one write per two cycles.
                if (ld_wr_req_i && !ack_q) begin
                    gnt = G_LD;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + (ADDR_W + 1)'(1);
                    end
                end else if (!ld_mode_i) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                stall   = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (!reset_i) begin
            gnt   = G_NONE;
            stall = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= RUN;
            gsrc_q  <= G_NONE;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gsrc_q  <= gnt;
            ack_q   <= (gnt == G_LD);
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        rom_addr_o = '0;
        unique case (gnt)
            G_IF:    rom_addr_o = if_addr_i;
            G_LD:    rom_addr_o = ld_addr_i;
`ifdef PRGROM_DBG_PORT_EN
            G_DBG:   rom_addr_o = dbg_addr_i;
`endif
            default: rom_addr_o = '0;
        endcase
    end

    assign rom_en_o    = (gnt != G_NONE);
    assign rom_we_o    = (gnt == G_LD);
    assign rom_wdata_o = (gnt == G_LD) ? ld_wdata_i : '0;

    // Read data is steered by who held the port on the previous cycle.
    assign if_valid_o    = reset_i && (gsrc_q == G_IF);
    assign if_rdata_o    = if_valid_o ? rom_rdata_i : '0;
    assign if_stall_o    = stall;
    assign ld_ack_o      = reset_i && ack_q;
    assign ld_count_o    = reset_i ? cnt_q : '0;
    assign cpu_hold_o    = reset_i && (state_q != RUN);
    assign cpu_restart_o = reset_i && (state_q == RELEASE);

`ifdef PRGROM_DBG_PORT_EN
    assign dbg_valid_o = reset_i && (gsrc_q == G_DBG);
    assign dbg_rdata_o = dbg_valid_o ? rom_rdata_i : '0;
`endif

endmodule

// File: tb/tb_prgrom_port_arbiter.sv
// tb/tb_prgrom_port_arbiter.sv - scoreboard bench for prgrom_port_arbiter with behavioural ROM
module tb_prgrom_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid, if_stall;
    logic          ld_mode, ld_wr_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_ack;
    logic [AW:0]   ld_count;
    logic          cpu_hold, cpu_restart;
    logic          rom_en, rom_we;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_wdata;
    logic [DW-1:0] rom_rdata = '0;
`ifdef PRGROM_DBG_PORT_EN
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_valid;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] q_if[$];
    logic [DW-1:0] q_dbg[$];
    logic [AW:0]   q_ack[$];
    int            q_rst[$];

    always #5 clock = ~clock;

    prgrom_port_arbiter dut (
        .clock_i       (clock),
        .reset_i       (rst_n),
        .if_req_i      (if_req),
        .if_addr_i     (if_addr),
        .if_rdata_o    (if_rdata),
        .if_valid_o    (if_valid),
        .if_stall_o    (if_stall),
        .ld_mode_i     (ld_mode),
        .ld_wr_req_i   (ld_wr_req),
        .ld_addr_i     (ld_addr),
        .ld_wdata_i    (ld_wdata),
        .ld_ack_o      (ld_ack),
        .ld_count_o    (ld_count),
        .cpu_hold_o    (cpu_hold),
        .cpu_restart_o (cpu_restart),
`ifdef PRGROM_DBG_PORT_EN
        .dbg_rd_req_i  (dbg_req),
        .dbg_addr_i    (dbg_addr),
        .dbg_rdata_o   (dbg_rdata),
        .dbg_valid_o   (dbg_valid),
`endif
        .rom_en_o      (rom_en),
        .rom_we_o      (rom_we),
        .rom_addr_o    (rom_addr),
        .rom_wdata_o   (rom_wdata),
        .rom_rdata_i   (rom_rdata)
    );

    function automatic logic [DW-1:0] rom_init(input logic [AW-1:0] a);
        return 32'hA500_0000 | DW'(a);
    endfunction

    // Behavioural ROM: unwritten words read back as rom_init(addr).
    logic [DW-1:0] wmem [int];
    always @(posedge clock) begin
        if (rom_en) begin
            if (rom_we) begin
                wmem[int'(rom_addr)] = rom_wdata;
            end else if (wmem.exists(int'(rom_addr))) begin
                rom_rdata <= wmem[int'(rom_addr)];
            end else begin
                rom_rdata <= rom_init(rom_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (if_valid) begin
            if (q_if.size() == 0) chk("if_valid_unexpected", 64'(if_valid), 64'd0);
            else chk("if_rdata", 64'(if_rdata), 64'(q_if.pop_front()));
        end
        if (ld_ack) begin
            if (q_ack.size() == 0) chk("ld_ack_unexpected", 64'(ld_ack), 64'd0);
            else chk("ld_count_at_ack", 64'(ld_count), 64'(q_ack.pop_front()));
        end
        if (cpu_restart) begin
            if (q_rst.size() == 0) chk("cpu_restart_unexpected", 64'(cpu_restart), 64'd0);
            else begin
                chk("cpu_restart_hold", 64'(cpu_hold), 64'd1);
                void'(q_rst.pop_front());
            end
        end
`ifdef PRGROM_DBG_PORT_EN
        if (dbg_valid) begin
            if (q_dbg.size() == 0) chk("dbg_valid_unexpected", 64'(dbg_valid), 64'd0);
            else chk("dbg_rdata", 64'(dbg_rdata), 64'(q_dbg.pop_front()));
        end
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        cyc();
        if_req  = 1'b1;
        if_addr = a;
        @(negedge clock);
        chk("fetch_rom_addr", 64'(rom_addr), 64'(a));
        chk("fetch_rom_en", 64'(rom_en), 64'd1);
        chk("fetch_stall", 64'(if_stall), 64'd0);
        q_if.push_back(exp);
    endtask

    task automatic ld_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [AW:0] cnt);
        cyc();
        ld_wr_req = 1'b1;
        ld_addr   = a;
        ld_wdata  = d;
        @(negedge clock);
        chk("ld_rom_we", 64'(rom_we), 64'd1);
        chk("ld_rom_addr", 64'(rom_addr), 64'(a));
        chk("ld_rom_wdata", 64'(rom_wdata), 64'(d));
        chk("ld_if_stall", 64'(if_stall), 64'd1);
        q_ack.push_back(cnt);
        cyc();
        @(negedge clock);
        chk("ld_no_regrant", 64'(rom_en), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b1; if_addr = 14'h0003;
        ld_mode = 1'b1; ld_wr_req = 1'b1; ld_addr = 14'h0001; ld_wdata = '1;
`ifdef PRGROM_DBG_PORT_EN
        dbg_req = 1'b1; dbg_addr = 14'h0002;
`endif
        // Reset with every request asserted
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_rom_en", 64'(rom_en), 64'd0);
        chk("rst_rom_we", 64'(rom_we), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_rom_wdata", 64'(rom_wdata), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_if_stall", 64'(if_stall), 64'd0);
        chk("rst_ld_ack", 64'(ld_ack), 64'd0);
        chk("rst_ld_count", 64'(ld_count), 64'd0);
        chk("rst_cpu_hold", 64'(cpu_hold), 64'd0);
        chk("rst_cpu_restart", 64'(cpu_restart), 64'd0);
        cyc();
        rst_n = 1'b1; if_req = 1'b0; ld_mode = 1'b0; ld_wr_req = 1'b0;
`ifdef PRGROM_DBG_PORT_EN
        dbg_req = 1'b0;
`endif

        // Plain fetches, including the top word
        fetch(14'h0010, 32'hA500_0010);
        fetch(14'h0123, 32'hA500_0123);
        fetch(14'h3FFF, 32'hA500_3FFF);
        cyc();
        if_req = 1'b0;

        // Programming session: ld_mode rises during a fetch
        fetch(14'h0020, 32'hA500_0020);
        ld_mode = 1'b1;
        cyc();
        if_addr = 14'h0021;
        @(negedge clock);
        chk("drain_hold", 64'(cpu_hold), 64'd1);
        chk("drain_no_grant", 64'(rom_en), 64'd0);
        chk("drain_stall", 64'(if_stall), 64'd1);
        ld_write(14'h0000, 32'hDEAD_0000, 15'd1);
        ld_write(14'h0001, 32'hDEAD_0001, 15'd2);
        ld_write(14'h0002, 32'hDEAD_0002, 15'd3);
        cyc();
        ld_wr_req = 1'b0; ld_mode = 1'b0;
        @(negedge clock);
        chk("load_end_hold", 64'(cpu_hold), 64'd1);
        chk("load_end_no_restart", 64'(cpu_restart), 64'd0);
        q_rst.push_back(1);
        cyc();
        if_req = 1'b0;
        @(negedge clock);
        chk("release_hold", 64'(cpu_hold), 64'd1);
        fetch(14'h0001, 32'hDEAD_0001);
        chk("run_after_session_hold", 64'(cpu_hold), 64'd0);
        chk("ld_count_held", 64'(ld_count), 64'd3);
        fetch(14'h0002, 32'hDEAD_0002);
        cyc();
        if_req = 1'b0;

        // ld_mode drops together with a write request
        ld_mode = 1'b1;
        cyc();
        @(negedge clock);
        chk("drain2_hold", 64'(cpu_hold), 64'd1);
        cyc();
        ld_mode = 1'b0; ld_wr_req = 1'b1; ld_addr = 14'h0005; ld_wdata = 32'h5555_AAAA;
        @(negedge clock);
        chk("pend_rom_we", 64'(rom_we), 64'd1);
        q_ack.push_back(15'd1);
        cyc();
        @(negedge clock);
        chk("pend_ack_cycle_we", 64'(rom_we), 64'd0);
        chk("pend_ack_cycle_restart", 64'(cpu_restart), 64'd0);
        q_rst.push_back(1);
        cyc();
        ld_wr_req = 1'b0;
        @(negedge clock);
        chk("pend_release_hold", 64'(cpu_hold), 64'd1);
        fetch(14'h0005, 32'h5555_AAAA);
        cyc();
        if_req = 1'b0;

        // Reset in the middle of a session
        ld_mode = 1'b1;
        cyc();
        @(negedge clock);
        ld_write(14'h0007, 32'h7777_0007, 15'd1);
        cyc();
        ld_wr_req = 1'b1; ld_addr = 14'h0008; ld_wdata = 32'h8888_0008; rst_n = 1'b0;
        @(negedge clock);
        chk("midrst_rom_we", 64'(rom_we), 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1; ld_mode = 1'b0; ld_wr_req = 1'b0;
        @(negedge clock);
        chk("midrst_ld_count", 64'(ld_count), 64'd0);
        chk("midrst_cpu_hold", 64'(cpu_hold), 64'd0);
        chk("midrst_cpu_restart", 64'(cpu_restart), 64'd0);
        fetch(14'h0008, 32'hA500_0008);
        fetch(14'h0007, 32'h7777_0007);
        cyc();
        if_req = 1'b0;

        // Stray loader writes while running
        for (int i = 0; i < 10; i++) begin
            cyc();
            ld_wr_req = 1'b1;
            ld_addr   = AW'(i);
            @(negedge clock);
            chk("stray_rom_we", 64'(rom_we), 64'd0);
        end
        cyc();
        ld_wr_req = 1'b0;

`ifdef PRGROM_DBG_PORT_EN
        // Fetch and debug both requesting: debug wins every fifth cycle
        for (int i = 0; i < 10; i++) begin
            cyc();
            if_req = 1'b1; dbg_req = 1'b1;
            if_addr  = AW'(14'h0030 + i);
            dbg_addr = AW'(14'h0100 + i);
            @(negedge clock);
            if ((i % 5) == 4) begin
                chk("dbg_forced_stall", 64'(if_stall), 64'd1);
                chk("dbg_forced_addr", 64'(rom_addr), 64'(dbg_addr));
                q_dbg.push_back(rom_init(AW'(14'h0100 + i)));
            end else begin
                chk("dbg_denied_stall", 64'(if_stall), 64'd0);
                chk("dbg_denied_addr", 64'(rom_addr), 64'(if_addr));
                q_if.push_back(rom_init(AW'(14'h0030 + i)));
            end
        end
        cyc();
        if_req = 1'b0; dbg_req = 1'b0;
`endif

        repeat (3) cyc();
        chk("q_if_drained", 64'(q_if.size()), 64'd0);
        chk("q_ack_drained", 64'(q_ack.size()), 64'd0);
        chk("q_rst_drained", 64'(q_rst.size()), 64'd0);
        chk("q_dbg_drained", 64'(q_dbg.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
